// File: rtl/spi_fifo_thresh.sv
// -----------------------------------------------------------------------------
// spi_fifo_thresh
//
// Synchronous FIFO that buffers SPI transfer bytes between the SPI shift engine
// and the SD-card command/data controllers.
//
// Features:
//   - Pushes are ignored when full and pops are ignored when empty.
//   - Programmable almost-full (AF_LEVEL) and almost-empty (AE_LEVEL) flags.
//   - Occupancy output.
//   - Sticky overflow/underflow flags, cleared by spi_fifo_err_clr.
//   - Optional first-word fall-through read mode, enabled by defining the
//     macro SPI_FIFO_FWFT_EN. When it is undefined (the default), reads are
//     registered.
//
// Ports:
//   clk, rst                  rising-edge clock; synchronous active-high reset
//   spi_fifo_wr_data/_wr_en   push data and push request
//   spi_fifo_wr_full          level == DEPTH
//   spi_fifo_wr_almost_full   level >= AF_LEVEL
//   spi_fifo_rd_en            pop request (acknowledges the head in FWFT mode)
//   spi_fifo_rd_data          read data
//   spi_fifo_rd_valid         registered mode: one-cycle pulse per accepted pop
//                             FWFT mode: !empty
//   spi_fifo_rd_empty         level == 0
//   spi_fifo_rd_almost_empty  level <= AE_LEVEL
//   spi_fifo_level            occupancy, 0..DEPTH
//   spi_fifo_overflow         sticky: push attempted while full
//   spi_fifo_underflow        sticky: pop attempted while empty
//   spi_fifo_err_clr          clears both sticky flags (a new error wins)
// -----------------------------------------------------------------------------
module spi_fifo_thresh #(
  parameter int DEPTH    = 512,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           spi_fifo_wr_data,
  input  logic                       spi_fifo_wr_en,
  output logic                       spi_fifo_wr_full,
  output logic                       spi_fifo_wr_almost_full,
  input  logic                       spi_fifo_rd_en,
  output logic [WIDTH-1:0]           spi_fifo_rd_data,
  output logic                       spi_fifo_rd_valid,
  output logic                       spi_fifo_rd_empty,
  output logic                       spi_fifo_rd_almost_empty,
  output logic [$clog2(DEPTH):0]     spi_fifo_level,
  output logic                       spi_fifo_overflow,
  output logic                       spi_fifo_underflow,
  input  logic                       spi_fifo_err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic full, empty, push_ok, pop_ok;

  // The flags come from the registered level only. Both acceptance decisions
  // use the current-cycle flags, so a pop while full frees no room for a push
  // in the same cycle.
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = spi_fifo_wr_en && !full;
  assign pop_ok  = spi_fifo_rd_en && !empty;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave a value unassigned. That is what keeps latches from being
  // inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A new error in the same cycle as err_clr wins over the clear.
    overflow_d  = (overflow_q  && !spi_fifo_err_clr) || (spi_fifo_wr_en && full);
    underflow_d = (underflow_q && !spi_fifo_err_clr) || (spi_fifo_rd_en && empty);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples values from before the edge. always_comb logic uses
  // blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset. Its contents are meaningless until
  // written, because the pointers and the level define what is valid. Leaving
  // out the reset lets the array map onto RAM.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr_q] <= spi_fifo_wr_data;
  end

`ifdef SPI_FIFO_FWFT_EN
  // First-word fall-through: the head word is shown combinationally.
  // rd_en only acknowledges the head.
  assign spi_fifo_rd_data  = empty ? '0 : mem[rd_ptr_q];
  assign spi_fifo_rd_valid = !empty;
`else
  // Registered read: a popped word appears after the edge, and rd_data holds
  // its value until the next accepted pop.
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = pop_ok;
    if (pop_ok) rd_data_d = mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign spi_fifo_rd_data  = rd_data_q;
  assign spi_fifo_rd_valid = rd_valid_q;
`endif

  assign spi_fifo_wr_full         = full;
  assign spi_fifo_rd_empty        = empty;
  assign spi_fifo_wr_almost_full  = (level_q >= LW'(AF_LEVEL));
  assign spi_fifo_rd_almost_empty = (level_q <= LW'(AE_LEVEL));
  assign spi_fifo_level           = level_q;
  assign spi_fifo_overflow        = overflow_q;
  assign spi_fifo_underflow       = underflow_q;

endmodule

// File: tb/tb_spi_fifo_thresh.sv
// -----------------------------------------------------------------------------
// tb_spi_fifo_thresh
//
// Self-checking bench for spi_fifo_thresh with DEPTH=8, WIDTH=8, AF_LEVEL=6
// and AE_LEVEL=1.
//
// The bench has three parts:
//   - A hand-computed vector table covering reset, fill, overflow, drain,
//     underflow and error clear.
//   - Hand-written multi-cycle corner sequences.
//   - A randomized run checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_spi_fifo_thresh;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en, rd_en, err_clr;
  logic             full, almost_full, rd_valid, empty, almost_empty;
  logic             overflow, underflow;
  logic [WIDTH-1:0] rd_data;
  logic [3:0]       level;

  spi_fifo_thresh #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .spi_fifo_wr_data         (wr_data),
    .spi_fifo_wr_en           (wr_en),
    .spi_fifo_wr_full         (full),
    .spi_fifo_wr_almost_full  (almost_full),
    .spi_fifo_rd_en           (rd_en),
    .spi_fifo_rd_data         (rd_data),
    .spi_fifo_rd_valid        (rd_valid),
    .spi_fifo_rd_empty        (empty),
    .spi_fifo_rd_almost_empty (almost_empty),
    .spi_fifo_level           (level),
    .spi_fifo_overflow        (overflow),
    .spi_fifo_underflow       (underflow),
    .spi_fifo_err_clr         (err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (queue of stored words) ----------------
  logic [7:0] mq[$];
  bit         m_ovf, m_udf, m_rdv;
  logic [7:0] m_rdd;

  task automatic model_step(input bit r, input bit w, input logic [7:0] d,
                            input bit rd, input bit c);
    bit was_full, was_empty;
    if (r) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_rdd = 8'h00; m_rdv = 0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      m_rdv = 0;
      if (rd && !was_empty) begin
        m_rdd = mq.pop_front();
        m_rdv = 1;
      end
      if (w && !was_full) mq.push_back(d);
      m_ovf = (m_ovf && !c) || (w && was_full);
      m_udf = (m_udf && !c) || (rd && was_empty);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    check({tag, ".level"},        32'(level),        32'(n));
    check({tag, ".full"},         32'(full),         32'(n == DEPTH));
    check({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF));
    check({tag, ".empty"},        32'(empty),        32'(n == 0));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    check({tag, ".underflow"},    32'(underflow),    32'(m_udf));
`ifdef SPI_FIFO_FWFT_EN
    check({tag, ".rd_data"},      32'(rd_data),      32'(n == 0 ? 8'h00 : mq[0]));
    check({tag, ".rd_valid"},     32'(rd_valid),     32'(n != 0));
`else
    check({tag, ".rd_data"},      32'(rd_data),      32'(m_rdd));
    check({tag, ".rd_valid"},     32'(rd_valid),     32'(m_rdv));
`endif
  endtask

  // Drive one cycle: inputs change 1 ns after a rising edge, and outputs are
  // sampled 1 ns after the next rising edge.
  task automatic step(input bit r, input bit w, input logic [7:0] d,
                      input bit rd, input bit c);
    rst = r; wr_en = w; wr_data = d; rd_en = rd; err_clr = c;
    @(posedge clk);
    model_step(r, w, d, rd, c);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rst, wen; logic [7:0] wd; bit ren, clr;
    int lvl; bit full, af, empty, ae, ovf, udf;
    logic [7:0] rdd; bit rdv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit w, logic [7:0] d, bit rd, bit c, int lvl,
                              bit ovf, bit udf, logic [7:0] rdd, bit rdv);
    vec_t v;
    v.rst = r; v.wen = w; v.wd = d; v.ren = rd; v.clr = c;
    v.lvl = lvl; v.full = (lvl == 8); v.af = (lvl >= 6);
    v.empty = (lvl == 0); v.ae = (lvl <= 1);
    v.ovf = ovf; v.udf = udf; v.rdd = rdd; v.rdv = rdv;
    return v;
  endfunction

  initial begin
    rst = 1; wr_en = 0; wr_data = 0; rd_en = 0; err_clr = 0;
    #1;

    // Fill the table: reset, idle, 8 pushes, overflow push, 8 pops,
    // underflow pop, error clear.
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, 8'(8'h10 + i), 0, 0, i + 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'hFF, 0, 0, 8, 1, 0, 8'h00, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 7 - i, 1, 0, 8'(8'h10 + i), 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h17, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h17, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wen, vecs[i].wd, vecs[i].ren, vecs[i].clr);
      check($sformatf("vec%0d.level", i),        32'(level),        32'(vecs[i].lvl));
      check($sformatf("vec%0d.full", i),         32'(full),         32'(vecs[i].full));
      check($sformatf("vec%0d.almost_full", i),  32'(almost_full),  32'(vecs[i].af));
      check($sformatf("vec%0d.empty", i),        32'(empty),        32'(vecs[i].empty));
      check($sformatf("vec%0d.almost_empty", i), 32'(almost_empty), 32'(vecs[i].ae));
      check($sformatf("vec%0d.overflow", i),     32'(overflow),     32'(vecs[i].ovf));
      check($sformatf("vec%0d.underflow", i),    32'(underflow),    32'(vecs[i].udf));
`ifndef SPI_FIFO_FWFT_EN
      check($sformatf("vec%0d.rd_data", i),      32'(rd_data),      32'(vecs[i].rdd));
      check($sformatf("vec%0d.rd_valid", i),     32'(rd_valid),     32'(vecs[i].rdv));
`endif
    end

    // ---------------- wrap-around ----------------
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin step(0, 1, 8'(8'h30 + i), 0, 0); check_model("wrap_push5"); end
    for (int i = 0; i < 5; i++) begin step(0, 0, 0, 1, 0); check_model("wrap_pop5"); end
    for (int i = 0; i < 8; i++) begin step(0, 1, 8'(8'hA0 + i), 0, 0); check_model("wrap_pushA"); end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 0);
`ifndef SPI_FIFO_FWFT_EN
      check("wrap_order", 32'(rd_data), 32'(8'hA0 + i));
`endif
      check_model("wrap_popA");
    end

    // ---------------- simultaneous push+pop at level 3 ----------------
    for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h50 + i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 8'(8'h60 + i), 1, 0);
      check("pp3_level", 32'(level), 32'd3);
      check_model("pp3");
    end

    // Push+pop at level 8: only the pop is accepted, and overflow is set.
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h70 + i), 0, 0);
    check("pp8_pre_full", 32'(full), 32'd1);
    step(0, 1, 8'hEE, 1, 0);
    check("pp8_level", 32'(level), 32'd7);
    check("pp8_ovf", 32'(overflow), 32'd1);
    check_model("pp8");

    // Push+pop at level 0: only the push is accepted, and underflow is set.
    step(1, 0, 0, 0, 0);
    step(0, 1, 8'hC3, 1, 0);
    check("pp0_level", 32'(level), 32'd1);
    check("pp0_udf", 32'(underflow), 32'd1);
    check("pp0_ovf", 32'(overflow), 32'd0);
    check_model("pp0");

    // A new error in the same cycle as err_clr wins over the clear.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);   // pops the single word
    step(0, 0, 0, 1, 1);   // underflow together with err_clr
    check("clr_vs_set_udf", 32'(underflow), 32'd1);
    check_model("clr_vs_set");

`ifdef SPI_FIFO_FWFT_EN
    // ---------------- FWFT head visibility ----------------
    step(1, 0, 0, 0, 0);
    step(0, 1, 8'h5A, 0, 0);
    check("fwft_data", 32'(rd_data), 32'h5A);
    check("fwft_valid", 32'(rd_valid), 32'd1);
    step(0, 0, 0, 1, 0);
    check("fwft_empty", 32'(empty), 32'd1);
    check("fwft_zero", 32'(rd_data), 32'h00);
`endif

    // ---------------- reset mid-burst at level 4 ----------------
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h90 + i), 0, 0);
    step(0, 1, 8'hBB, 1, 0);   // level stays 4
    step(0, 1, 8'hBC, 0, 0);   // level 5
    step(0, 1, 8'hBD, 1, 0);   // level 5
    step(0, 0, 0, 1, 0);       // level 4; rd_valid pulses
    check("mid_level4", 32'(level), 32'd4);
    step(1, 1, 8'hCC, 1, 0);   // push/pop together with rst are ignored
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_model("rst_mid");

    // ---------------- randomized run ----------------
    for (int i = 0; i < 3000; i++) begin
      bit r, w, rd, c;
      int wp;
      wp = ((i / 150) % 2) ? 75 : 30;   // alternate filling and draining phases
      r  = ($urandom_range(0, 299) == 0);
      w  = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < (100 - wp));
      c  = ($urandom_range(0, 24) == 0);
      step(r, w, 8'($urandom), rd, c);
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
